mmc_cmd_sched: RTL and testbench

Per-channel DRAM command scheduler in the main memory controller. It accepts in-order read/write requests from the MMC request queue and tracks the open page of every bank. It generates the activate (page-open), precharge (page-close) and column command sequence with minimum spacing. It drives one channel's `mmc__dfi__cs/cmd1/cmd0/bank/addr` lanes, which the DFI block converts SDR to DDR; one instance exists per channel.

---
 rtl/mmc_sched_pkg.sv | 29 ++
 rtl/mmc_bank_table.sv | 38 +++
 rtl/mmc_cmd_sched.sv | 231 +++++++++++++++++++++++
 tb/tb_mmc_cmd_sched.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mmc_sched_pkg.sv
// Shared command encodings, FSM states and default timing for the per-channel
// DRAM command scheduler.
package mmc_sched_pkg;

  localparam logic [1:0] CMD_PO = 2'b00;
  localparam logic [1:0] CMD_PC = 2'b01;
  localparam logic [1:0] CMD_RD = 2'b10;
  localparam logic [1:0] CMD_WR = 2'b11;

  localparam int T_PO_DEF     = 3;
  localparam int T_PC_DEF     = 3;
  localparam int T_CCD_DEF    = 2;
  localparam int T_COL_PC_DEF = 2;

  // Width of every spacing counter; all timing parameters must fit.
  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CHECK   = 3'd1,
    ST_PC      = 3'd2,
    ST_WAIT_PC = 3'd3,
    ST_PO      = 3'd4,
    ST_WAIT_PO = 3'd5,
    ST_COL     = 3'd6,
    ST_CLOSE   = 3'd7
  } sched_state_e;

endpackage

// File: rtl/mmc_bank_table.sv
// Per-bank open flag and open page storage: one combinational read port, one
// write port, asynchronously cleared so every bank starts closed.
module mmc_bank_table #(
  parameter int BANK_W = 5,
  parameter int PAGE_W = 13
) (
  input  logic              clk,
  input  logic              rst_ni,
  input  logic [BANK_W-1:0] rd_bank_i,
  output logic              rd_open_o,
  output logic [PAGE_W-1:0] rd_page_o,
  input  logic              wr_en_i,
  input  logic [BANK_W-1:0] wr_bank_i,
  input  logic              wr_open_i,
  input  logic [PAGE_W-1:0] wr_page_i
);

  localparam int NUM_BANKS = 2**BANK_W;

  logic [NUM_BANKS-1:0] open_q;
  logic [PAGE_W-1:0]    page_q [NUM_BANKS];

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      open_q <= '0;
      for (int i = 0; i < NUM_BANKS; i++) begin
        page_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      open_q[wr_bank_i] <= wr_open_i;
      page_q[wr_bank_i] <= wr_page_i;
    end
  end

  assign rd_open_o = open_q[rd_bank_i];
  assign rd_page_o = page_q[rd_bank_i];

endmodule

// File: rtl/mmc_cmd_sched.sv
// Per-channel DRAM command scheduler: PO/PC/RD/WR sequencing with bank page
// tracking. Define MMC_SCHED_CLOSED_PAGE_EN for a closed-page policy.
module mmc_cmd_sched
  import mmc_sched_pkg::*;
#(
  parameter int BANK_W   = 5,
  parameter int PAGE_W   = 13,
  parameter int LINE_W   = 7,
  parameter int T_PO     = T_PO_DEF,
  parameter int T_PC     = T_PC_DEF,
  parameter int T_CCD    = T_CCD_DEF,
  parameter int T_COL_PC = T_COL_PC_DEF
) (
  input  logic              clk,
  input  logic              reset_poweron,
  input  logic              dfi__sched__init_done,
  input  logic              req__sched__valid,
  input  logic              req__sched__write,
  input  logic [BANK_W-1:0] req__sched__bank,
  input  logic [PAGE_W-1:0] req__sched__page,
  input  logic [LINE_W-1:0] req__sched__line,
  output logic              sched__req__ready,
  output logic              sched__dfi__cs,
  output logic              sched__dfi__cmd1,
  output logic              sched__dfi__cmd0,
  output logic [BANK_W-1:0] sched__dfi__bank,
  output logic [PAGE_W-1:0] sched__dfi__addr,
  output logic              sched__rd_issue,
  output logic              sched__wr_issue
);

  sched_state_e state_q, state_d;

  logic              req_write_q;
  logic [BANK_W-1:0] req_bank_q;
  logic [PAGE_W-1:0] req_page_q;
  logic [LINE_W-1:0] req_line_q;

  logic [CNT_W-1:0]  wait_q, wait_d, ccd_q, ccd_d, colpc_q, colpc_d;
  logic [BANK_W-1:0] colpc_bank_q, colpc_bank_d;

  logic              ready_q, ready_d, cs_q, cs_d, rd_q, rd_d, wr_q, wr_d;
  logic [1:0]        cmd_q, cmd_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic [PAGE_W-1:0] addr_q, addr_d;

  logic              tbl_open_s, tbl_we_s, tbl_wr_open_s, accept_s, ccd_ok_s, colpc_ok_s;
  logic [PAGE_W-1:0] tbl_page_s, line_ext_s;

  mmc_bank_table #(.BANK_W(BANK_W), .PAGE_W(PAGE_W)) u_bank_table (
    .clk       (clk),
    .rst_ni    (reset_poweron),
    .rd_bank_i (req_bank_q),
    .rd_open_o (tbl_open_s),
    .rd_page_o (tbl_page_s),
    .wr_en_i   (tbl_we_s),
    .wr_bank_i (req_bank_q),
    .wr_open_i (tbl_wr_open_s),
    .wr_page_i (req_page_q)
  );

  assign accept_s   = req__sched__valid & ready_q;
  assign ccd_ok_s   = (ccd_q == '0);
  // The column-to-PC counter only restrains the bank that issued the last column.
  assign colpc_ok_s = (colpc_q == '0) || (colpc_bank_q != req_bank_q);

  always_comb begin
    line_ext_s                = '0;
    line_ext_s[LINE_W-1:0]    = req_line_q;
  end

  // Each state_d entering PC/PO/COL registers that command, so it is visible
  // in the same cycle the FSM occupies the command state.
  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    ccd_d         = (ccd_q != '0) ? ccd_q - 1'b1 : ccd_q;
    colpc_d       = (colpc_q != '0) ? colpc_q - 1'b1 : colpc_q;
    colpc_bank_d  = colpc_bank_q;
    tbl_we_s      = 1'b0;
    tbl_wr_open_s = 1'b0;
    cs_d          = 1'b0;
    cmd_d         = 2'b00;
    bank_d        = '0;
    addr_d        = '0;
    rd_d          = 1'b0;
    wr_d          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept_s) state_d = ST_CHECK;
        else          state_d = ST_IDLE;
      end
      ST_CHECK: begin
        if (tbl_open_s && (tbl_page_s == req_page_q)) begin
          if (ccd_ok_s) state_d = ST_COL;
          else          state_d = ST_CHECK;
        end else if (!tbl_open_s) begin
          state_d = ST_PO;
        end else if (colpc_ok_s) begin
          state_d = ST_PC;
        end else begin
          state_d = ST_CHECK;
        end
      end
      ST_PC: begin
        wait_d = CNT_W'(T_PC - 2);
`ifdef MMC_SCHED_CLOSED_PAGE_EN
        state_d = ST_IDLE;
`else
        state_d = ST_WAIT_PC;
`endif
      end
      ST_WAIT_PC: begin
        if (wait_q == '0) state_d = ST_PO;
        else              wait_d  = wait_q - 1'b1;
      end
      ST_PO: begin
        wait_d  = CNT_W'(T_PO - 2);
        state_d = ST_WAIT_PO;
      end
      ST_WAIT_PO: begin
        if (wait_q != '0) wait_d  = wait_q - 1'b1;
        else if (ccd_ok_s) state_d = ST_COL;
        else               state_d = ST_WAIT_PO;
      end
      ST_COL: begin
`ifdef MMC_SCHED_CLOSED_PAGE_EN
        state_d = ST_CLOSE;
`else
        state_d = ST_IDLE;
`endif
      end
      ST_CLOSE: begin
        if (colpc_ok_s) state_d = ST_PC;
        else            state_d = ST_CLOSE;
      end
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_PC: begin
        cs_d          = 1'b1;
        cmd_d         = CMD_PC;
        bank_d        = req_bank_q;
        tbl_we_s      = 1'b1;
        tbl_wr_open_s = 1'b0;
      end
      ST_PO: begin
        cs_d          = 1'b1;
        cmd_d         = CMD_PO;
        bank_d        = req_bank_q;
        addr_d        = req_page_q;
        tbl_we_s      = 1'b1;
        tbl_wr_open_s = 1'b1;
      end
      ST_COL: begin
        cs_d         = 1'b1;
        cmd_d        = req_write_q ? CMD_WR : CMD_RD;
        bank_d       = req_bank_q;
        addr_d       = line_ext_s;
        rd_d         = ~req_write_q;
        wr_d         = req_write_q;
        ccd_d        = CNT_W'(T_CCD - 1);
        colpc_d      = CNT_W'(T_COL_PC - 1);
        colpc_bank_d = req_bank_q;
      end
      default: begin
        cs_d = 1'b0;
      end
    endcase

    ready_d = (state_d == ST_IDLE) && dfi__sched__init_done;
  end

  // FSM, spacing counters and registered DFI outputs.
  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      state_q      <= ST_IDLE;
      wait_q       <= '0;
      ccd_q        <= '0;
      colpc_q      <= '0;
      colpc_bank_q <= '0;
      ready_q      <= 1'b0;
      cs_q         <= 1'b0;
      cmd_q        <= 2'b00;
      bank_q       <= '0;
      addr_q       <= '0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      ccd_q        <= ccd_d;
      colpc_q      <= colpc_d;
      colpc_bank_q <= colpc_bank_d;
      ready_q      <= ready_d;
      cs_q         <= cs_d;
      cmd_q        <= cmd_d;
      bank_q       <= bank_d;
      addr_q       <= addr_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
    end
  end

  // Request capture on handshake.
  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      req_write_q <= 1'b0;
      req_bank_q  <= '0;
      req_page_q  <= '0;
      req_line_q  <= '0;
    end else if (accept_s) begin
      req_write_q <= req__sched__write;
      req_bank_q  <= req__sched__bank;
      req_page_q  <= req__sched__page;
      req_line_q  <= req__sched__line;
    end
  end

  assign sched__req__ready = ready_q;
  assign sched__dfi__cs    = cs_q;
  assign sched__dfi__cmd1  = cmd_q[1];
  assign sched__dfi__cmd0  = cmd_q[0];
  assign sched__dfi__bank  = bank_q;
  assign sched__dfi__addr  = addr_q;
  assign sched__rd_issue   = rd_q;
  assign sched__wr_issue   = wr_q;

endmodule

// File: tb/tb_mmc_cmd_sched.sv
// Self-checking bench for mmc_cmd_sched: a timeline model predicts the cycle of
// every PC/PO/column command and the return of ready for each request.
module tb_mmc_cmd_sched;

  localparam int BANK_W = 5, PAGE_W = 13, LINE_W = 7;
  localparam int T_PO = 3, T_PC = 3, T_CCD = 2, T_COL_PC = 2;
`ifdef MMC_SCHED_CLOSED_PAGE_EN
  localparam bit CLOSED = 1'b1;
`else
  localparam bit CLOSED = 1'b0;
`endif

  logic              clk, rst_n, init_done, valid, write;
  logic [BANK_W-1:0] bank;
  logic [PAGE_W-1:0] page;
  logic [LINE_W-1:0] line;
  logic              ready, cs, cmd1, cmd0, rd_issue, wr_issue;
  logic [BANK_W-1:0] o_bank;
  logic [PAGE_W-1:0] o_addr;

  mmc_cmd_sched dut (
    .clk                   (clk),
    .reset_poweron         (rst_n),
    .dfi__sched__init_done (init_done),
    .req__sched__valid     (valid),
    .req__sched__write     (write),
    .req__sched__bank      (bank),
    .req__sched__page      (page),
    .req__sched__line      (line),
    .sched__req__ready     (ready),
    .sched__dfi__cs        (cs),
    .sched__dfi__cmd1      (cmd1),
    .sched__dfi__cmd0      (cmd0),
    .sched__dfi__bank      (o_bank),
    .sched__dfi__addr      (o_addr),
    .sched__rd_issue       (rd_issue),
    .sched__wr_issue       (wr_issue)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0, cyc = 0;
  bit m_open [32];
  int m_page [32];
  int last_col, last_bank;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // Layout: {cs, cmd[1:0], bank[4:0], addr[12:0], rd, wr, ready}
  function automatic logic [31:0] pack(bit c, logic [1:0] cm, int b, int a, bit r, bit w, bit rdy);
    logic [31:0] v;
    v = 32'h0;
    v[23]    = c;
    v[22:21] = cm;
    v[20:16] = b[4:0];
    v[15:3]  = a[12:0];
    v[2]     = r;
    v[1]     = w;
    v[0]     = rdy;
    return v;
  endfunction

  function automatic logic [31:0] obs_vec();
    return pack(cs, {cmd1, cmd0}, int'(o_bank), int'(o_addr), rd_issue, wr_issue, ready);
  endfunction

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_open[i] = 1'b0;
      m_page[i] = 0;
    end
    last_col  = -100;
    last_bank = -1;
  endtask

  function automatic int imax(int a, int b);
    return (a > b) ? a : b;
  endfunction

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      tick();
      check_eq("idle", obs_vec(), pack(1'b0, 2'b00, 0, 0, 1'b0, 1'b0, init_done));
    end
  endtask

  // Called in a cycle where ready is expected high; returns in the cycle ready is back.
  task automatic do_req(input bit wr, input int b, input int pg, input int ln);
    int n, pc_c, po_c, col_c, cl_c, end_c;
    logic [31:0] e;
    check_eq("ready_pre", {31'h0, ready}, 32'h1);
    valid = 1'b1; write = wr; bank = b[4:0]; page = pg[12:0]; line = ln[6:0];
    n = cyc;
    pc_c = -1; po_c = -1; cl_c = -1;
    if (m_open[b] && m_page[b] == pg) begin
      col_c = imax(n + 2, last_col + T_CCD);
    end else if (!m_open[b]) begin
      po_c  = n + 2;
      col_c = imax(po_c + T_PO, last_col + T_CCD);
    end else begin
      pc_c  = n + 2;
      if (b == last_bank) pc_c = imax(pc_c, last_col + T_COL_PC);
      po_c  = pc_c + T_PC;
      col_c = imax(po_c + T_PO, last_col + T_CCD);
    end
    m_open[b] = 1'b1; m_page[b] = pg;
    last_col = col_c; last_bank = b;
    if (CLOSED) begin
      cl_c = col_c + T_COL_PC;
      m_open[b] = 1'b0;
      end_c = cl_c;
    end else begin
      end_c = col_c;
    end
    tick();
    valid = 1'b0;
    for (int c = n + 1; c <= end_c + 1; c++) begin
      if (c == pc_c || c == cl_c)
        e = pack(1'b1, 2'b01, b, 0, 1'b0, 1'b0, 1'b0);
      else if (c == po_c)
        e = pack(1'b1, 2'b00, b, pg, 1'b0, 1'b0, 1'b0);
      else if (c == col_c)
        e = pack(1'b1, wr ? 2'b11 : 2'b10, b, ln, !wr, wr, 1'b0);
      else
        e = pack(1'b0, 2'b00, 0, 0, 1'b0, 1'b0, (c == end_c + 1) ? init_done : 1'b0);
      check_eq((c == col_c) ? "col" : (c == po_c) ? "po" : (c == pc_c || c == cl_c) ? "pc" : "gap", obs_vec(), e);
      if (c < end_c + 1) tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; init_done = 1'b0; valid = 1'b0; write = 1'b0;
    bank = '0; page = '0; line = '0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("reset_outs", obs_vec(), 32'h0);
    end
    rst_n = 1'b1;
    tick();
    check_eq("ready_no_init", obs_vec(), 32'h0);
    init_done = 1'b1;
    tick();
    check_eq("ready_after_init", obs_vec(), pack(1'b0, 2'b00, 0, 0, 1'b0, 1'b0, 1'b1));

    // Abort a closed-bank read in WAIT_PO, then retry it.
    valid = 1'b1; write = 1'b0; bank = 5'd5; page = 13'h33; line = 7'd9;
    n = cyc;
    tick();
    valid = 1'b0;
    check_eq("abort_check", obs_vec(), 32'h0);
    tick();
    check_eq("abort_po", obs_vec(), pack(1'b1, 2'b00, 5, 'h33, 1'b0, 1'b0, 1'b0));
    tick();
    rst_n = 1'b0;
    #1;
    check_eq("abort_rst", obs_vec(), 32'h0);
    model_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("abort_held", obs_vec(), 32'h0);
    end
    rst_n = 1'b1;
    tick();
    check_eq("ready_after_abort", {31'h0, ready}, 32'h1);
    do_req(1'b0, 5, 'h33, 9);

    // Reset while ready is high must drop it immediately.
    rst_n = 1'b0;
    #1;
    check_eq("rst_ready_clear", obs_vec(), 32'h0);
    model_reset();
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("ready_after_rst", {31'h0, ready}, 32'h1);

    do_req(1'b0, 3, 'h10, 5);
    do_req(1'b1, 3, 'h10, 7);
    do_req(1'b0, 3, 'h20, 1);
    idle(2);
    do_req(1'b0, 1, 'h7, 0);
    do_req(1'b0, 1, 'h7, 2);

    // init_done low blocks acceptance even with valid held high.
    init_done = 1'b0;
    tick();
    check_eq("init_low_ready", obs_vec(), 32'h0);
    valid = 1'b1; write = 1'b1; bank = 5'd2; page = 13'h1; line = 7'd3;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("init_low_block", obs_vec(), 32'h0);
    end
    valid = 1'b0;
    init_done = 1'b1;
    tick();
    check_eq("init_restore", {31'h0, ready}, 32'h1);

    for (int k = 0; k < 40; k++) begin
      int b, pg;
      case ($urandom_range(0, 2))
        0:       b = 3;
        1:       b = 1;
        default: b = int'($urandom_range(0, 31));
      endcase
      pg = int'($urandom_range(0, 2)) * 'h100 + b;
      idle(int'($urandom_range(0, 2)));
      do_req(1'($urandom_range(0, 1)), b, pg, int'($urandom_range(0, 127)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
